// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/hz_md_timer.sv
// Mul/div wait down-counter: loadable, decrementing, with a flag that the
// current decrement is the one that brings the count to zero.
module hz_md_timer #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  output logic             last_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loading LAT-1 and leaving when the count steps to zero gives LAT-1 wait
  // cycles, so the issue cycle plus the wait totals LAT cycles of hold.
  assign last_o = (cnt_q <= CNT_W'(1));
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use, branch,
// jr redirect and mul/div hold. Define HAZARD_PERF_EN to add perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_muldiv,
  input  logic       id_branch_taken,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_jr_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifflush,
  output logic       idex_bubble,
`ifdef HAZARD_PERF_EN
  output logic       busy,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`else
  output logic       busy
`endif
);

  localparam bit MD_HOLD = (MULDIV_LAT > 1);

  hz_state_t        state_q, state_d;
  logic             luse;
  logic             md_load, md_dec, md_clr, md_last;
  logic [CNT_W-1:0] md_cnt;

  assign luse = ex_memread && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  hz_md_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (MULDIV_LAT - 1)
  ) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (md_clr),
    .load_i (md_load),
    .dec_i  (md_dec),
    .last_o (md_last),
    .cnt_o  (md_cnt)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    md_load     = 1'b0;
    md_dec      = 1'b0;
    md_clr      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifflush     = 1'b0;
    idex_bubble = 1'b0;
    busy        = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifflush     = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_jr_taken) begin
            ifflush     = 1'b1;
            idex_bubble = 1'b1;
          end else if (luse) begin
            // Branch operands are not ready yet; it re-resolves next cycle.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_muldiv) begin
            pc_write   = id_branch_taken;
            ifid_write = 1'b0;
            ifflush    = id_branch_taken;
            if (MD_HOLD) begin
              state_d = MD_WAIT;
              md_load = 1'b1;
            end
          end else if (id_branch_taken) begin
            ifflush = 1'b1;
          end
        end
        MD_WAIT: begin
          busy = 1'b1;
          if (ex_jr_taken) begin
            ifflush     = 1'b1;
            idex_bubble = 1'b1;
            md_clr      = 1'b1;
            state_d     = RUN;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            md_dec      = 1'b1;
            if (md_last) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_write) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ifflush)   perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// hand-written multi-cycle sequences (reset, mul/div hold, jr abort).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_muldiv, id_branch_taken, ex_memread, ex_jr_taken;
  logic       pc_write, ifid_write, ifflush, idex_bubble, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int unsigned exp_stall = 0, exp_flush = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_muldiv       (id_muldiv),
    .id_branch_taken (id_branch_taken),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_jr_taken     (ex_jr_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifflush         (ifflush),
    .idex_bubble     (idex_bubble),
`ifdef HAZARD_PERF_EN
    .busy            (busy),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`else
    .busy            (busy)
`endif
  );

  // Expected output word is {pc_write, ifid_write, ifflush, idex_bubble, busy}.
  typedef struct {
    string      nm;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       muldiv;
    logic       br;
    logic       memread;
    logic [4:0] exrt;
    logic       jr;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic md, input logic br, input logic mr,
                       input logic [4:0] ert, input logic jr);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; id_muldiv = md;
    id_branch_taken = br; ex_memread = mr; ex_rt = ert; ex_jr_taken = jr;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Samples outputs mid-cycle, compares under mask, then advances to just
  // after the next rising edge so the caller can drive the following cycle.
  task automatic tick(input string nm, input logic [4:0] exp, input logic [4:0] msk);
    logic [4:0] got;
    @(negedge clk);
    got = {pc_write, ifid_write, ifflush, idex_bubble, busy};
    n_vec++;
    if ((got & msk) !== (exp & msk)) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (mask %b)", nm, got, exp, msk);
    end
`ifdef HAZARD_PERF_EN
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp[4]) exp_stall++;
      if (exp[2])  exp_flush++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    //            name          rs     rt     urt   md    br    mr    exrt   jr    exp
    tbl[0]  = '{"idle",       5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'b11000};
    tbl[1]  = '{"luse_rs",    5'd8,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 5'b00010};
    tbl[2]  = '{"luse_r0",    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 5'b11000};
    tbl[3]  = '{"luse_rt",    5'd3,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'b00010};
    tbl[4]  = '{"rt_unused",  5'd3,  5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'b11000};
    tbl[5]  = '{"no_load",    5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 5'b11000};
    tbl[6]  = '{"branch",     5'd4,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'b11100};
    tbl[7]  = '{"br_luse",    5'd7,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 5'b00010};
    tbl[8]  = '{"jr_all",     5'd7,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  1'b1, 5'b11110};
    tbl[9]  = '{"jr_muldiv",  5'd1,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'b11110};
    tbl[10] = '{"br_r0_load", 5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'b11100};
    tbl[11] = '{"miss_rs",    5'd6,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 5'b11000};

    // Reset held two cycles with a mul/div sitting in ID.
    rst = 1'b1;
    drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick("rst_c0", 5'b00110, 5'b11111);
    tick("rst_c1", 5'b00110, 5'b11111);
    rst = 1'b0;
    idle();
    tick("post_rst", 5'b11000, 5'b11111);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].muldiv, tbl[i].br,
            tbl[i].memread, tbl[i].exrt, tbl[i].jr);
      tick(tbl[i].nm, tbl[i].exp, 5'b11111);
    end

    // Branch blocked by load-use, then resolves once the load moves on.
    drive(5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    tick("br_held", 5'b00010, 5'b11111);
    drive(5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    tick("br_go", 5'b11100, 5'b11111);

    // Mul/div issue with LAT=4: four cycles of pc_write=0, busy on the last three.
    idle();
    id_muldiv = 1'b1;
    tick("md_issue", 5'b00000, 5'b11111);
    idle();
    ex_memread = 1'b1; ex_rt = 5'd1;
    tick("md_wait1", 5'b00011, 5'b11111);
    idle();
    tick("md_wait2", 5'b00011, 5'b11111);
    tick("md_wait3", 5'b00011, 5'b11111);
    tick("md_done", 5'b11000, 5'b11111);
    tick("md_after", 5'b11000, 5'b11111);

    // Reset landing in the second wait cycle cancels the remaining hold.
    id_muldiv = 1'b1;
    tick("md2_issue", 5'b00000, 5'b11111);
    idle();
    tick("md2_wait1", 5'b00011, 5'b11111);
    rst = 1'b1;
    tick("md2_rst", 5'b00110, 5'b11111);
    rst = 1'b0;
    tick("md2_run0", 5'b11000, 5'b11111);
    tick("md2_run1", 5'b11000, 5'b11111);

    // Mul/div paired with a taken branch: redirect this cycle, then the hold.
    drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick("mdbr_issue", 5'b10100, 5'b10111);
    idle();
    tick("mdbr_wait1", 5'b00011, 5'b11111);
    tick("mdbr_wait2", 5'b00011, 5'b11111);
    tick("mdbr_wait3", 5'b00011, 5'b11111);
    tick("mdbr_done", 5'b11000, 5'b11111);

    // A jr appearing during the wait wins and returns the FSM to RUN.
    id_muldiv = 1'b1;
    tick("mdjr_issue", 5'b00000, 5'b11111);
    idle();
    ex_jr_taken = 1'b1;
    tick("mdjr_jr", 5'b11111, 5'b11111);
    idle();
    tick("mdjr_run", 5'b11000, 5'b11111);
    tick("mdjr_run2", 5'b11000, 5'b11111);

`ifdef HAZARD_PERF_EN
    n_vec++;
    if (perf_stall_cnt !== exp_stall) begin
      n_err++;
      $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, exp_stall);
    end
    n_vec++;
    if (perf_flush_cnt !== exp_flush) begin
      n_err++;
      $display("FAIL perf_flush: got %0d expected %0d", perf_flush_cnt, exp_flush);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
